vdma_wr_burst_arbiter: RTL and testbench
========================================

Name: vdma_wr_burst_arbiter

Overview:
- Shares one AXI write-address/command path between NUM_CH write channels.
- Each channel is driven by its own FIFO status controller, which raises burst/tail requests with a beat length.
- The block arbitrates round-robin, forms the AXI address from a per-channel base plus a running pointer, and issues one command.
- It then returns resp (command accepted) and done (write response received) to the granted channel; the data mux downstream follows grant_ch.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8).
- LSIZE, 9, width of each channel request length (beats).
- ADDR_W, 32, AXI address width.
- BEAT_BYTES, 8, bytes per data beat (power of two).
- MAX_BEATS, 256, longest legal burst; longer requests are clamped.

Ports:
- clock  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ch_burst_req  in  NUM_CH  per-channel full-burst request (level)
- ch_tail_req  in  NUM_CH  per-channel tail request (level)
- ch_req_len  in  NUM_CH*LSIZE  per-channel length in beats; channel i at [i*LSIZE +: LSIZE]
- ch_base_addr  in  NUM_CH*ADDR_W  per-channel frame base address
- ch_frame_start  in  NUM_CH  one-cycle pulse: clear that channel's pointer
- ch_resp  out  NUM_CH  one-cycle pulse to the granted channel when its command is accepted
- ch_done  out  NUM_CH  one-cycle pulse to the granted channel when the write completes
- cmd_valid  out  1  AXI-style command valid
- cmd_ready  in  1  command accepted
- cmd_addr  out  ADDR_W  burst start address
- cmd_len  out  8  AXI awlen (beats-1)
- cmd_done  in  1  write-response pulse for the outstanding command
- grant_ch  out  $clog2(NUM_CH)  currently granted channel (data mux select)
- busy  out  1  high outside IDLE
- len_err  out  1  sticky; set when any granted length exceeded MAX_BEATS

Behaviour:
- Reset values: all outputs 0; pointers 0; rr pointer last = NUM_CH-1, so ch0 wins first.
- Eligibility: channel i is eligible when (ch_burst_req[i] | ch_tail_req[i]) and ch_req_len[i] != 0. A request with length 0 is never granted.
- FSM states:
  - IDLE: if any channel is eligible -> ARB; else stay.
  - ARB: register winner = first eligible channel searching from last+1 with wrap; register grant_ch, clamped length L = min(len, MAX_BEATS) and cmd_addr = base + ptr. If len > MAX_BEATS, set len_err. -> ISSUE.
  - ISSUE: cmd_valid=1; cmd_addr/cmd_len held stable, cmd_len = L-1. On cmd_valid&cmd_ready: ch_resp[grant]=1 for that cycle -> WAIT_DONE.
  - WAIT_DONE: on cmd_done, ch_done[grant]=1 for that cycle; ptr[grant] += L*BEAT_BYTES; last = grant -> IDLE.
- Latency: an eligible request seen in IDLE raises cmd_valid 2 cycles later. Back-to-back grants take at least 3 cycles after done.
- If the eligible set changes during ARB, the winner is determined by the values sampled in IDLE->ARB evaluation (registered at ARB). A requester dropping its request after grant does not abort the command.
- Only one command is outstanding. cmd_done outside WAIT_DONE is ignored; cmd_ready outside ISSUE is ignored.
- ch_frame_start[i] while channel i is not granted: ptr[i] <= 0 next cycle.
- ch_frame_start[i] while i is granted (ARB..WAIT_DONE): the clear is deferred. At release, ptr[i] <= 0 instead of the increment.
- Pointer addition wraps modulo 2^ADDR_W with no error.
- Async reset mid-transaction: immediate return to IDLE with all outputs 0. The downstream AXI side must be reset together with this block.

Optional Feature:
- Macro: VDMA_ARB_TAIL_PRIORITY_EN.
- Defined: in ARB, if any eligible channel has ch_tail_req set, only tail-requesting channels compete (round-robin among them). Burst-only channels wait.
- Undefined: burst and tail requests are treated identically in a single round-robin.

Decomposition:
- Package vdma_arb_pkg holds:
  - the FSM state enum (IDLE, ARB, ISSUE, WAIT_DONE);
  - a localparam for the awlen width (8);
  - a function clamp_len(len, max).
- Sub-module vdma_rr_pick: combinational round-robin picker (eligible vector + last pointer -> winner index + any_valid). It is instantiated once in ARB.

Test Plan:
- Single channel: ch1 burst, len=200, base=0x1000_0000, cmd_ready tied 1 -> cmd_addr=0x1000_0000, cmd_len=199, ch_resp[1] pulse. After cmd_done, ch_done[1] pulse; next request addr=0x1000_0640.
- Round-robin: all 4 channels request continuously, len=16 -> grant order 0,1,2,3,0; no channel granted twice before the others.
- Backpressure: hold cmd_ready=0 for 10 cycles -> cmd_valid stays high with addr/len stable; ch_resp pulses only in the handshake cycle.
- Clamp and zero: len=300 -> cmd_len=255, len_err=1, ptr advances 2048 bytes. len=0 with req high -> never granted, busy stays 0.
- Frame start during WAIT_DONE on the granted channel -> after done, the next command from that channel uses addr=base. A frame start on an idle channel clears it in 1 cycle.
- Tail priority (macro defined): ch0 burst and ch2 tail requesting simultaneously, last=3 -> ch2 granted first. With the macro undefined, ch0 is granted first.

Source files
------------

// File: rtl/vdma_wr_burst_arbiter_pkg.sv
// Shared types and helpers for the VDMA write-command arbiter.
package vdma_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARB       = 2'd1,
    ISSUE     = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

  localparam int AWLEN_W = 8;

  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max);
    return (len > max) ? max : len;
  endfunction

endpackage

// File: rtl/vdma_wr_burst_arbiter_if.sv
// AXI-style write-command channel between the arbiter (master) and the AXI side (slave).
interface vdma_wr_burst_arbiter_if
  import vdma_arb_pkg::*;
#(
  parameter int ADDR_W = 32
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [AWLEN_W-1:0] cmd_len;
  logic               cmd_done;

  modport master (output cmd_valid, cmd_addr, cmd_len, input cmd_ready, cmd_done);
  modport slave  (input cmd_valid, cmd_addr, cmd_len, output cmd_ready, cmd_done);
endinterface

// File: rtl/vdma_rr_pick.sv
// Combinational round-robin picker: first set bit of elig_i searching from last_i+1 with wrap.
module vdma_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  elig_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int c;

  // Scan farthest-first so the nearest candidate after last_i is the final assignment.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    c     = 0;
    for (int k = N; k >= 1; k--) begin
      c = (32'(last_i) + k) % N;
      if (elig_i[c]) begin
        idx_o = IW'(c);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vdma_wr_burst_arbiter.sv
// Round-robin sharing of one AXI write-command path across NUM_CH channels.
// Define VDMA_ARB_TAIL_PRIORITY_EN to let tail requests pre-empt burst-only requesters.
module vdma_wr_burst_arbiter
  import vdma_arb_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int LSIZE      = 9,
  parameter int ADDR_W     = 32,
  parameter int BEAT_BYTES = 8,
  parameter int MAX_BEATS  = 256
) (
  input  logic                       clock,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          ch_burst_req,
  input  logic [NUM_CH-1:0]          ch_tail_req,
  input  logic [NUM_CH*LSIZE-1:0]    ch_req_len,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_base_addr,
  input  logic [NUM_CH-1:0]          ch_frame_start,
  output logic [NUM_CH-1:0]          ch_resp,
  output logic [NUM_CH-1:0]          ch_done,
  vdma_wr_burst_arbiter_if.master    cmd,
  output logic [$clog2(NUM_CH)-1:0]  grant_ch,
  output logic                       busy,
  output logic                       len_err
);

  localparam int IW  = $clog2(NUM_CH);
  localparam int BSH = $clog2(BEAT_BYTES);

  arb_state_e                     state_q, state_d;
  logic [IW-1:0]                  last_q, grant_q, pick_idx, gnt_idx;
  logic                           pick_any;
  logic [NUM_CH-1:0]              elig, elig_q, cand;
  logic [AWLEN_W-1:0]             len_q;
  logic [ADDR_W-1:0]              addr_q, inc;
  logic [NUM_CH-1:0][ADDR_W-1:0]  ptr_q;
  logic                           len_err_q, fs_pend_q;
  logic [LSIZE-1:0]               sel_len;
  logic [ADDR_W-1:0]              sel_base;
  int unsigned                    sel_clamp;
  logic                           sel_over, held, release_c;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_CH; i++)
      elig[i] = (ch_burst_req[i] | ch_tail_req[i]) && (ch_req_len[i*LSIZE +: LSIZE] != '0);
  end

`ifdef VDMA_ARB_TAIL_PRIORITY_EN
  logic [NUM_CH-1:0] tail_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)              tail_q <= '0;
    else if (state_q == IDLE) tail_q <= ch_tail_req & elig;
  end

  assign cand = (|(elig_q & tail_q)) ? (elig_q & tail_q) : elig_q;
`else
  assign cand = elig_q;
`endif

  vdma_rr_pick #(.N(NUM_CH), .IW(IW)) u_pick (
    .elig_i (cand),
    .last_i (last_q),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  assign sel_len   = ch_req_len[32'(pick_idx)*LSIZE +: LSIZE];
  assign sel_base  = ch_base_addr[32'(pick_idx)*ADDR_W +: ADDR_W];
  assign sel_clamp = clamp_len(32'(sel_len), 32'(MAX_BEATS));
  assign sel_over  = 32'(sel_len) > 32'(MAX_BEATS);

  // During ARB the channel being granted is the picker's output, not yet grant_q.
  assign held      = (state_q != IDLE);
  assign gnt_idx   = (state_q == ARB) ? pick_idx : grant_q;
  assign release_c = (state_q == WAIT_DONE) && cmd.cmd_done;
  assign inc       = ({{(ADDR_W-AWLEN_W){1'b0}}, len_q} + ADDR_W'(1)) << BSH;

  always_comb begin
    state_d = state_q;
    ch_resp = '0;
    ch_done = '0;
    case (state_q)
      IDLE:      if (|elig) state_d = ARB;
      ARB:       state_d = pick_any ? ISSUE : IDLE;
      ISSUE: begin
        if (cmd.cmd_ready) begin
          ch_resp[grant_q] = 1'b1;
          state_d          = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (cmd.cmd_done) begin
          ch_done[grant_q] = 1'b1;
          state_d          = IDLE;
        end
      end
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      last_q    <= IW'(NUM_CH-1);
      grant_q   <= '0;
      elig_q    <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      len_err_q <= 1'b0;
      fs_pend_q <= 1'b0;
      ptr_q     <= '0;
    end else begin
      if (state_q == IDLE) elig_q <= elig;

      if (state_q == ARB && pick_any) begin
        grant_q <= pick_idx;
        len_q   <= AWLEN_W'(sel_clamp - 1);
        addr_q  <= sel_base + ptr_q[pick_idx];
        if (sel_over) len_err_q <= 1'b1;
      end

      for (int i = 0; i < NUM_CH; i++)
        if (ch_frame_start[i] && !(held && IW'(i) == gnt_idx)) ptr_q[i] <= '0;

      // A frame start on the active channel is remembered and applied at release.
      if (state_q == IDLE)                    fs_pend_q <= 1'b0;
      else if (ch_frame_start[gnt_idx])       fs_pend_q <= 1'b1;

      if (release_c) begin
        ptr_q[grant_q] <= (fs_pend_q || ch_frame_start[grant_q]) ? '0 : ptr_q[grant_q] + inc;
        last_q         <= grant_q;
        fs_pend_q      <= 1'b0;
      end
    end
  end

  assign cmd.cmd_valid = (state_q == ISSUE);
  assign cmd.cmd_addr  = addr_q;
  assign cmd.cmd_len   = len_q;
  assign grant_ch      = grant_q;
  assign busy          = held;
  assign len_err       = len_err_q;

endmodule

// File: tb/tb_vdma_wr_burst_arbiter.sv
// Randomized bench for vdma_wr_burst_arbiter against a transaction-level reference model.
module tb_vdma_wr_burst_arbiter;

  localparam int NUM_CH = 4, LSIZE = 9, ADDR_W = 32, BEAT_BYTES = 8, MAX_BEATS = 256, IW = 2;
`ifdef VDMA_ARB_TAIL_PRIORITY_EN
  localparam bit TAILPRI = 1'b1;
`else
  localparam bit TAILPRI = 1'b0;
`endif

  logic                      clock = 1'b0;
  logic                      rst_n;
  logic [NUM_CH-1:0]         burst, tail, fs;
  logic [NUM_CH*LSIZE-1:0]   lenbus;
  logic [NUM_CH*ADDR_W-1:0]  basebus;
  logic [NUM_CH-1:0]         ch_resp, ch_done;
  logic [IW-1:0]             grant_ch;
  logic                      busy, len_err;

  vdma_wr_burst_arbiter_if #(.ADDR_W(ADDR_W)) cmd_if ();

  vdma_wr_burst_arbiter #(
    .NUM_CH(NUM_CH), .LSIZE(LSIZE), .ADDR_W(ADDR_W), .BEAT_BYTES(BEAT_BYTES), .MAX_BEATS(MAX_BEATS)
  ) dut (
    .clock(clock), .rst_n(rst_n),
    .ch_burst_req(burst), .ch_tail_req(tail), .ch_req_len(lenbus),
    .ch_base_addr(basebus), .ch_frame_start(fs),
    .ch_resp(ch_resp), .ch_done(ch_done), .cmd(cmd_if),
    .grant_ch(grant_ch), .busy(busy), .len_err(len_err)
  );

  always #5 clock = ~clock;

  int          n_chk = 0, n_fail = 0;
  int unsigned m_ptr [NUM_CH];
  int          m_last;
  bit          m_len_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Arbitration rule: nearest eligible after the last winner; tail requesters first when enabled.
  function automatic int mpick(input logic [NUM_CH-1:0] e, input logic [NUM_CH-1:0] t, input int last);
    logic [NUM_CH-1:0] c;
    c = (TAILPRI && (e & t) != '0) ? (e & t) : e;
    for (int k = 1; k <= NUM_CH; k++)
      if (c[(last + k) % NUM_CH]) return (last + k) % NUM_CH;
    return -1;
  endfunction

  task automatic set_req(input int ch, input bit is_tail, input int len);
    burst[ch] = !is_tail;
    tail[ch]  = is_tail;
    lenbus[ch*LSIZE +: LSIZE] = LSIZE'(len);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) m_ptr[i] = 0;
    m_last    = NUM_CH - 1;
    m_len_err = 1'b0;
  endtask

  // One full command: arbitration, optional backpressure, wait with frame starts, completion.
  // Entered and left on a falling edge with the DUT idle.
  task automatic do_round(input bit drop, input int fs_sel, output int o_ch,
                          output logic [31:0] o_addr, output logic [7:0] o_len);
    logic [NUM_CH-1:0] e, t;
    logic [31:0]       ea;
    int                win, n, L, rlen, k, w, fch;
    bit                defer;
    for (int i = 0; i < NUM_CH; i++) begin
      e[i] = (burst[i] | tail[i]) && (lenbus[i*LSIZE +: LSIZE] != '0);
      t[i] = tail[i] & e[i];
    end
    win = mpick(e, t, m_last);
    o_ch = -1; o_addr = '0; o_len = '0;
    chk("eligible_any", 64'(e != '0), 64'd1);
    if (win < 0) return;
    rlen = int'(lenbus[win*LSIZE +: LSIZE]);
    L    = (rlen > MAX_BEATS) ? MAX_BEATS : rlen;
    ea   = basebus[win*ADDR_W +: ADDR_W] + m_ptr[win];
    if (rlen > MAX_BEATS) m_len_err = 1'b1;

    n = 0;
    while (cmd_if.cmd_valid !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    chk("issue_latency", 64'(n), 64'd2);
    if (n >= 20) return;
    chk("grant_ch", 64'(grant_ch), 64'(win));
    chk("cmd_addr", 64'(cmd_if.cmd_addr), 64'(ea));
    chk("cmd_len", 64'(cmd_if.cmd_len), 64'(L - 1));
    chk("len_err", 64'(len_err), 64'(m_len_err));
    chk("busy_issue", 64'(busy), 64'd1);
    o_ch = int'(grant_ch); o_addr = cmd_if.cmd_addr; o_len = cmd_if.cmd_len;

    k = $urandom_range(0, 4);
    for (int j = 0; j < k; j++) begin
      cmd_if.cmd_ready = 1'b0;
      cmd_if.cmd_done  = 1'($urandom_range(0, 1));
      #1 chk("resp_stall", 64'(ch_resp), 64'd0);
      @(negedge clock);
      chk("hold_cmd", {31'd0, cmd_if.cmd_valid, cmd_if.cmd_addr}, {31'd0, 1'b1, ea});
      chk("hold_len", 64'(cmd_if.cmd_len), 64'(L - 1));
    end
    cmd_if.cmd_done  = 1'b0;
    cmd_if.cmd_ready = 1'b1;
    #1 chk("resp_pulse", 64'(ch_resp), 64'(1 << win));
    @(negedge clock);
    cmd_if.cmd_ready = 1'($urandom_range(0, 1));
    #1 chk("valid_drop", {62'd0, cmd_if.cmd_valid, |ch_resp}, 64'd0);
    if (drop) begin burst[win] = 1'b0; tail[win] = 1'b0; end

    defer = 1'b0;
    w = $urandom_range(0, 3);
    if (fs_sel >= 0 && w == 0) w = 1;
    for (int j = 0; j < w; j++) begin
      fs = '0; fch = -1;
      if (fs_sel >= 0 && j == 0) fch = fs_sel;
      else if (fs_sel == -2 && $urandom_range(0, 2) == 0) fch = $urandom_range(0, NUM_CH-1);
      if (fch >= 0) begin
        fs[fch] = 1'b1;
        if (fch == win) defer = 1'b1; else m_ptr[fch] = 0;
      end
      #1 chk("done_early", 64'(ch_done), 64'd0);
      @(negedge clock);
    end
    fs = '0;
    if (fs_sel == -2 && $urandom_range(0, 3) == 0) begin
      fch = $urandom_range(0, NUM_CH-1);
      fs[fch] = 1'b1;
      if (fch == win) defer = 1'b1; else m_ptr[fch] = 0;
    end
    cmd_if.cmd_ready = 1'b0;
    cmd_if.cmd_done  = 1'b1;
    #1 chk("done_pulse", 64'(ch_done), 64'(1 << win));
    m_ptr[win] = defer ? 0 : m_ptr[win] + L * BEAT_BYTES;
    m_last     = win;
    @(negedge clock);
    cmd_if.cmd_done = 1'b0;
    fs = '0;
    #1 chk("idle_after_done", {62'd0, busy, |ch_done}, 64'd0);
  endtask

  int          och, ncnt;
  logic [31:0] oaddr;
  logic [7:0]  olen;
  int          rr_exp [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n = 1'b0; burst = '0; tail = '0; fs = '0; lenbus = '0;
    cmd_if.cmd_ready = 1'b0; cmd_if.cmd_done = 1'b0;
    for (int i = 0; i < NUM_CH; i++) basebus[i*ADDR_W +: ADDR_W] = $urandom;
    basebus[1*ADDR_W +: ADDR_W] = 32'h1000_0000;
    basebus[3*ADDR_W +: ADDR_W] = 32'h3000_0000;
    model_reset();
    repeat (3) @(negedge clock);
    chk("rst_outs", {cmd_if.cmd_valid, busy, len_err, grant_ch, ch_resp, ch_done}, '0);
    chk("rst_cmd", {cmd_if.cmd_addr, cmd_if.cmd_len}, '0);
    rst_n = 1'b1;
    @(negedge clock);

    // Zero-length requests must never be granted.
    burst = '1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clock);
      chk("zero_len_idle", {62'd0, busy, cmd_if.cmd_valid}, 64'd0);
    end
    burst = '0;

    // ch0 burst vs ch2 tail with last = NUM_CH-1.
    set_req(0, 1'b0, 16); set_req(2, 1'b1, 16);
    do_round(1'b1, -1, och, oaddr, olen);
    chk("tail_first", 64'(och), TAILPRI ? 64'd2 : 64'd0);
    do_round(1'b1, -1, och, oaddr, olen);
    chk("tail_second", 64'(och), TAILPRI ? 64'd0 : 64'd2);

    // Single channel, pointer advance of 200 beats.
    set_req(1, 1'b0, 200);
    do_round(1'b1, -1, och, oaddr, olen);
    chk("single_addr", 64'(oaddr), 64'h1000_0000);
    chk("single_len", 64'(olen), 64'd199);
    set_req(1, 1'b0, 200);
    do_round(1'b1, -1, och, oaddr, olen);
    chk("single_addr2", 64'(oaddr), 64'h1000_0640);

    // Clamp: 300 beats -> 256, pointer steps 2048 bytes.
    set_req(3, 1'b0, 300);
    do_round(1'b1, -1, och, oaddr, olen);
    chk("clamp_len", 64'(olen), 64'd255);
    chk("clamp_err", 64'(len_err), 64'd1);
    set_req(3, 1'b0, 8);
    do_round(1'b1, -1, och, oaddr, olen);
    chk("clamp_addr", 64'(oaddr), 64'h3000_0800);

    // Continuous requests from every channel.
    for (int i = 0; i < NUM_CH; i++) set_req(i, 1'b0, 16);
    for (int j = 0; j < 5; j++) begin
      do_round(1'b0, -1, och, oaddr, olen);
      chk("rr_order", 64'(och), 64'(rr_exp[j]));
    end
    burst = '0; tail = '0;

    // Frame start on the active channel is applied at completion.
    set_req(1, 1'b0, 4);
    do_round(1'b1, 1, och, oaddr, olen);
    set_req(1, 1'b0, 4);
    do_round(1'b1, -1, och, oaddr, olen);
    chk("fs_deferred", 64'(oaddr), 64'h1000_0000);

    // Frame start on an idle channel.
    fs[3] = 1'b1; m_ptr[3] = 0;
    @(negedge clock);
    fs = '0;
    set_req(3, 1'b0, 1);
    do_round(1'b1, -1, och, oaddr, olen);
    chk("fs_idle", 64'(oaddr), 64'h3000_0000);

    // Random traffic.
    for (int r = 0; r < 60; r++) begin
      int ne;
      for (int i = 0; i < NUM_CH; i++)
        if (!(burst[i] | tail[i]) && $urandom_range(0, 1) == 1)
          set_req(i, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 320));
      ne = 0;
      for (int i = 0; i < NUM_CH; i++)
        if ((burst[i] | tail[i]) && lenbus[i*LSIZE +: LSIZE] != '0) ne++;
      if (ne == 0) set_req($urandom_range(0, NUM_CH-1), 1'($urandom_range(0, 1)), $urandom_range(1, 300));
      do_round(1'b1, -2, och, oaddr, olen);
    end

    // Asynchronous reset while a command is pending.
    burst = '0; tail = '0;
    set_req(2, 1'b0, 10);
    ncnt = 0;
    while (cmd_if.cmd_valid !== 1'b1 && ncnt < 20) begin @(negedge clock); ncnt++; end
    chk("pre_reset_valid", 64'(cmd_if.cmd_valid), 64'd1);
    cmd_if.cmd_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk("async_rst_outs", {cmd_if.cmd_valid, busy, len_err, grant_ch, ch_resp, ch_done}, '0);
    chk("async_rst_cmd", {cmd_if.cmd_addr, cmd_if.cmd_len}, '0);
    cmd_if.cmd_ready = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    model_reset();
    do_round(1'b1, -1, och, oaddr, olen);
    chk("post_reset_ch", 64'(och), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
